// File: rtl/dac_spi_tx.sv
// SPI transmitter for a quad 12-bit DAC: one 32-bit frame per start, MSB first, SCK idle low.
// Optional DAC_SPI_READBACK_EN captures the DAC's SDO echo into rb_data at the end of each frame.
module dac_spi_tx #(
    parameter int CLK_HALF = 2,
    parameter int CS_GAP   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  cmd,
    input  logic [3:0]  addr,
    input  logic [11:0] data,
    output logic        busy,
    output logic        done,
    output logic [31:0] rb_data,
    input  logic        dac_out,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        dac_cs_n,
    output logic        dac_clr_n
);

    localparam int HW = $clog2(CLK_HALF + 1);
    localparam int GW = $clog2(CS_GAP + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_HALF - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    logic [1:0]    state;
    logic [31:0]   tx_sr;
    logic [4:0]    bit_cnt;
    logic [HW-1:0] half_cnt;
    logic [GW-1:0] gap_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tx_sr     <= '0;
            bit_cnt   <= '0;
            half_cnt  <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
            dac_cs_n  <= 1'b1;
            dac_clr_n <= 1'b0;
        end else begin
            dac_clr_n <= 1'b1;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_sr    <= {8'h00, cmd, addr, data, 4'h0};
                        bit_cnt  <= '0;
                        half_cnt <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // First SHIFT cycle (chip-select still high) only launches the frame.
                    if (dac_cs_n) begin
                        dac_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        spi_mosi <= tx_sr[31];
                        spi_sck  <= 1'b0;
                        half_cnt <= '0;
                    end else if (half_cnt != HALF_LAST) begin
                        half_cnt <= half_cnt + 1'b1;
                    end else begin
                        half_cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                        end else begin
                            spi_sck <= 1'b0;
                            if (bit_cnt == 5'd31) begin
                                spi_mosi <= 1'b0;
                                state    <= HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt + 1'b1;
                                tx_sr    <= {tx_sr[30:0], 1'b0};
                                spi_mosi <= tx_sr[30];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (half_cnt != HALF_LAST) begin
                        half_cnt <= half_cnt + 1'b1;
                    end else begin
                        half_cnt <= '0;
                        dac_cs_n <= 1'b1;
                        gap_cnt  <= '0;
                        state    <= GAP;
                    end
                end
                default: begin
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef DAC_SPI_READBACK_EN
    logic [31:0] rx_sr;
    logic        sck_rise_edge;
    logic        frame_end_edge;

    // Same conditions the main FSM uses to raise SCK and to issue done.
    assign sck_rise_edge  = (state == SHIFT) && !dac_cs_n && (half_cnt == HALF_LAST) && !spi_sck;
    assign frame_end_edge = (state == GAP) && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sr   <= '0;
            rb_data <= '0;
        end else begin
            if (sck_rise_edge)
                rx_sr <= {rx_sr[30:0], dac_out};
            if (frame_end_edge)
                rb_data <= rx_sr;
        end
    end
`else
    logic unused_dac_out;
    assign unused_dac_out = dac_out;
    assign rb_data        = 32'h0;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx at CLK_HALF=2, CS_GAP=2: frame content, pin timing, ignored/held start,
// mid-frame reset and (when DAC_SPI_READBACK_EN is defined) SDO readback.
module tb_dac_spi_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  cmd = 4'h0;
    logic [3:0]  addr = 4'h0;
    logic [11:0] data = 12'h000;
    logic        busy, done, spi_sck, spi_mosi, dac_cs_n, dac_clr_n;
    logic [31:0] rb_data;
    logic        dac_out = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    dac_spi_tx #(.CLK_HALF(2), .CS_GAP(2)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd), .addr(addr), .data(data),
        .busy(busy), .done(done), .rb_data(rb_data), .dac_out(dac_out),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .dac_cs_n(dac_cs_n), .dac_clr_n(dac_clr_n)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- driver tasks ----------------
    // Drive a request at a negedge; t0 is the index of the posedge that samples it.
    task automatic start_frame(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d,
                               input logic keep, output int t0);
        cmd = c; addr = a; data = d; start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        if (!keep) start = 1'b0;
    endtask

    // Observe pins each negedge until done (or stop_bit SCK rises), optionally pulsing start at pulse_bit.
    task automatic watch_frame(input logic [31:0] rb_pat, input int pulse_bit, input int stop_bit,
                               output logic [31:0] word, output int rises, output int first_rise,
                               output int cs_fall, output int cs_rise, output int done_cyc,
                               output int busy_first, output int busy_last, output int glitches);
        logic prev_sck, prev_mosi, prev_cs;
        bit   pulsing;
        word = '0; rises = 0; first_rise = -1; cs_fall = -1; cs_rise = -1; done_cyc = -1;
        busy_first = -1; busy_last = -1; glitches = 0; pulsing = 0;
        prev_sck = spi_sck; prev_mosi = spi_mosi; prev_cs = dac_cs_n;
        dac_out = rb_pat[31];
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (spi_sck && !prev_sck) begin
                if (rises == 0) first_rise = cyc;
                word = {word[30:0], spi_mosi};
                rises++;
            end
            if (spi_mosi !== prev_mosi && !(prev_sck && !spi_sck) && !(prev_cs && !dac_cs_n))
                glitches++;
            if (!dac_cs_n && cs_fall < 0) cs_fall = cyc;
            if (dac_cs_n && cs_fall >= 0 && cs_rise < 0) cs_rise = cyc;
            if (busy) begin
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
            prev_sck = spi_sck; prev_mosi = spi_mosi; prev_cs = dac_cs_n;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (stop_bit >= 0 && rises == stop_bit) break;
            if (!spi_sck && rises < 32) dac_out = rb_pat[31 - rises];
            if (pulsing) begin
                start = 1'b0;
                pulsing = 0;
            end else if (pulse_bit >= 0 && rises == pulse_bit && !spi_sck && first_rise >= 0) begin
                start = 1'b1;
                pulsing = 1;
                pulse_bit = -1;
            end
        end
        start = (pulsing) ? 1'b0 : start;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        vectors++; if (dac_cs_n !== 1'b1) begin miscompares++; $display("FAIL rst_cs_n got=%b exp=1", dac_cs_n); end
        vectors++; if (spi_sck !== 1'b0) begin miscompares++; $display("FAIL rst_sck got=%b exp=0", spi_sck); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL rst_busy_done got=%b%b exp=00", busy, done); end
        vectors++; if (rb_data !== 32'h0) begin miscompares++; $display("FAIL rst_rb_data got=%h exp=0", rb_data); end
        reset = 1'b0;
        #1;
        vectors++; if (dac_clr_n !== 1'b0) begin miscompares++; $display("FAIL rst_clr_held got=%b exp=0", dac_clr_n); end
        @(negedge clk);
        vectors++; if (dac_clr_n !== 1'b1) begin miscompares++; $display("FAIL rst_clr_release got=%b exp=1", dac_clr_n); end
        vectors++; if (dac_cs_n !== 1'b1 || spi_mosi !== 1'b0) begin miscompares++; $display("FAIL rst_idle_pins got=%b%b exp=10", dac_cs_n, spi_mosi); end
    endtask

    task automatic test_single_frame();
        logic [31:0] w; int t0, r, fr, cf, cr, dc, bf, bl, g;
        start_frame(4'h3, 4'hF, 12'hABC, 1'b0, t0);
        watch_frame(32'h0, -1, -1, w, r, fr, cf, cr, dc, bf, bl, g);
        vectors++; if (w !== 32'h003FABC0) begin miscompares++; $display("FAIL single_word got=%h exp=003fabc0", w); end
        vectors++; if (r !== 32) begin miscompares++; $display("FAIL single_rises got=%0d exp=32", r); end
        vectors++; if (cf - t0 !== 1) begin miscompares++; $display("FAIL single_cs_fall got=t0+%0d exp=t0+1", cf - t0); end
        vectors++; if (fr - t0 !== 3) begin miscompares++; $display("FAIL single_first_rise got=t0+%0d exp=t0+3", fr - t0); end
        vectors++; if (cr - cf !== 130) begin miscompares++; $display("FAIL single_cs_low got=%0d exp=130", cr - cf); end
        vectors++; if (dc - t0 !== 133) begin miscompares++; $display("FAIL single_done got=t0+%0d exp=t0+133", dc - t0); end
        vectors++; if (bf - t0 !== 1 || bl - t0 !== 132) begin miscompares++; $display("FAIL single_busy got=t0+%0d..t0+%0d exp=t0+1..t0+132", bf - t0, bl - t0); end
        vectors++; if (g !== 0) begin miscompares++; $display("FAIL single_mosi_stable got=%0d exp=0", g); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_at_done got=%b exp=0", busy); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL single_done_width got=%b exp=0", done); end
    endtask

    task automatic test_ignore_start();
        logic [31:0] w; int t0, r, fr, cf, cr, dc, bf, bl, g, extra;
        start_frame(4'h3, 4'h1, 12'h5A5, 1'b0, t0);
        watch_frame(32'h0, 10, -1, w, r, fr, cf, cr, dc, bf, bl, g);
        vectors++; if (w !== 32'h00315A50) begin miscompares++; $display("FAIL ignore_word got=%h exp=00315a50", w); end
        vectors++; if (dc - t0 !== 133) begin miscompares++; $display("FAIL ignore_done got=t0+%0d exp=t0+133", dc - t0); end
        start = 1'b0;
        extra = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done || busy || !dac_cs_n) extra++;
        end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL ignore_no_second_frame got=%0d exp=0", extra); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w1, w2; int t0, r, fr, cf1, cr1, dc1, cf2, cr2, dc2, bf, bl, g;
        start_frame(4'h3, 4'h0, 12'h001, 1'b1, t0);
        watch_frame(32'h0, -1, -1, w1, r, fr, cf1, cr1, dc1, bf, bl, g);
        data = 12'h002;
        watch_frame(32'h0, -1, -1, w2, r, fr, cf2, cr2, dc2, bf, bl, g);
        start = 1'b0;
        vectors++; if (w1 !== 32'h00300010) begin miscompares++; $display("FAIL b2b_word1 got=%h exp=00300010", w1); end
        vectors++; if (w2 !== 32'h00300020) begin miscompares++; $display("FAIL b2b_word2 got=%h exp=00300020", w2); end
        vectors++; if (cf2 - dc1 !== 2) begin miscompares++; $display("FAIL b2b_accept got=done+%0d exp=done+2", cf2 - dc1); end
        vectors++; if (cf2 - cr1 !== 4) begin miscompares++; $display("FAIL b2b_cs_gap got=%0d exp=4", cf2 - cr1); end
        vectors++; if (dc2 - dc1 !== 134) begin miscompares++; $display("FAIL b2b_done_spacing got=%0d exp=134", dc2 - dc1); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [31:0] w; int t0, r, fr, cf, cr, dc, bf, bl, g, extra;
        start_frame(4'h3, 4'hF, 12'hFFF, 1'b0, t0);
        watch_frame(32'h0, -1, 20, w, r, fr, cf, cr, dc, bf, bl, g);
        reset = 1'b1;
        #1;
        vectors++; if (dac_cs_n !== 1'b1 || spi_sck !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midrst_pins got=cs%b sck%b busy%b exp=cs1 sck0 busy0", dac_cs_n, spi_sck, busy); end
        vectors++; if (dac_clr_n !== 1'b0 || spi_mosi !== 1'b0) begin miscompares++; $display("FAIL midrst_clr_mosi got=%b%b exp=00", dac_clr_n, spi_mosi); end
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done || busy || !dac_cs_n) extra++;
        end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL midrst_no_done got=%0d exp=0", extra); end
        start_frame(4'h2, 4'h1, 12'h555, 1'b0, t0);
        watch_frame(32'h0, -1, -1, w, r, fr, cf, cr, dc, bf, bl, g);
        vectors++; if (w !== 32'h00215550) begin miscompares++; $display("FAIL midrst_next_word got=%h exp=00215550", w); end
        vectors++; if (dc - t0 !== 133) begin miscompares++; $display("FAIL midrst_next_done got=t0+%0d exp=t0+133", dc - t0); end
    endtask

    task automatic test_readback();
        logic [31:0] w, exp_rb; int t0, r, fr, cf, cr, dc, bf, bl, g;
`ifdef DAC_SPI_READBACK_EN
        exp_rb = 32'hDEADBEEF;
`else
        exp_rb = 32'h0;
`endif
        start_frame(4'h3, 4'h2, 12'h123, 1'b0, t0);
        watch_frame(32'hDEADBEEF, -1, -1, w, r, fr, cf, cr, dc, bf, bl, g);
        vectors++; if (rb_data !== exp_rb) begin miscompares++; $display("FAIL readback_at_done got=%h exp=%h", rb_data, exp_rb); end
        dac_out = 1'b0;
        repeat (5) @(negedge clk);
        vectors++; if (rb_data !== exp_rb) begin miscompares++; $display("FAIL readback_held got=%h exp=%h", rb_data, exp_rb); end
        vectors++; if (w !== 32'h00321230) begin miscompares++; $display("FAIL readback_word got=%h exp=00321230", w); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_single_frame();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        test_readback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- SPI transmitter for the board's quad 12-bit DAC (LTC2624-class, 32-bit frame); the write-direction counterpart to our ADC capture block on the same shared SPI bus.
- Accepts one command/address/data word per start request and serializes it MSB-first with its own chip-select.
- Generates SCK from the system clock and reports completion with a one-cycle done pulse.
- Sits between the control/sequencer logic and the FPGA DAC pins (SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR).

Parameters:
- CLK_HALF, 2: system clocks per SCK half-period; SCK = clk/(2*CLK_HALF); legal values ≥1.
- CS_GAP, 2: minimum system clocks that dac_cs_n stays high after a frame before done/next frame; legal values ≥1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- start  input  1  frame request; sampled only when busy=0.
- cmd  input  4  DAC command nibble.
- addr  input  4  DAC channel address nibble.
- data  input  12  DAC code.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at end of frame.
- rb_data  output  32  readback word (see Optional Feature).
- dac_out  input  1  DAC SDO pin.
- spi_sck  output  1  SPI clock; idle low.
- spi_mosi  output  1  serial data to DAC.
- dac_cs_n  output  1  chip-select, active low.
- dac_clr_n  output  1  DAC clear, active low.

Behaviour:
- Reset values (asynchronous): busy=0, done=0, spi_sck=0, spi_mosi=0, dac_cs_n=1, dac_clr_n=0, rb_data=0, state=IDLE.
- dac_clr_n goes to 1 on the first clk edge after reset deasserts.
- All outputs are registered; there are no combinational paths from inputs to pins.
- Frame word, latched at accept: [31:24]=8'h00, [23:20]=cmd, [19:16]=addr, [15:4]=data, [3:0]=4'h0.
- Inputs are don't-care after the accept cycle.
- States: IDLE, SHIFT, HOLD, GAP.
- IDLE:
  - If start=1, latch the word and go to SHIFT.
  - On the next edge: dac_cs_n=0, busy=1, spi_mosi=bit31, spi_sck=0.
- SHIFT: 32 bits.
  - Each bit: SCK low for CLK_HALF clks, then high for CLK_HALF clks.
  - MOSI is stable for the whole bit and changes only on the clk edge where SCK falls. The DAC samples on SCK rise.
  - After the 32nd high phase: SCK=0, MOSI=0, go to HOLD.
- HOLD: SCK low for CLK_HALF clks, then dac_cs_n=1, go to GAP.
- GAP:
  - Hold dac_cs_n=1 for CS_GAP clks.
  - Then done=1 and busy=0 in the same cycle, and return to IDLE.
- Timing, with t0 = the start-sampling edge:
  - dac_cs_n falls at t0+1.
  - SCK rises exactly 32 times, the first at t0+1+CLK_HALF.
  - dac_cs_n rises at t0+1+65*CLK_HALF.
  - done is high during cycle t0+1+65*CLK_HALF+CS_GAP.
- start while busy=1: ignored, not queued.
- start held high across done: a new frame is accepted at the first IDLE cycle, i.e. the cycle after done.
- Reset mid-frame: pins return to reset values immediately; the partial frame is discarded and no done pulse is issued.
- Bit, half-period and gap counters are sized from the parameters and never wrap inside a frame.

Optional Feature:
- Macro: DAC_SPI_READBACK_EN.
- Defined:
  - dac_out is sampled on each clk edge where spi_sck rises and shifted into a 32-bit register, MSB first.
  - rb_data is updated with the full 32-bit word on the done cycle and held until the next done.
  - This word is the frame the DAC echoes (the previously sent word).
- Undefined: dac_out is ignored and rb_data is constant 0; all other behaviour is identical.

Test Plan:
- Reset release → dac_cs_n=1, sck=0, busy=0, rb_data=0; dac_clr_n=0 until the first edge after reset deasserts, then 1.
- CLK_HALF=2, CS_GAP=2; start with cmd=4'h3, addr=4'hF, data=12'hABC → MOSI bits sampled on SCK rises = 32'h003FABC0; exactly 32 SCK rises; dac_cs_n low for 130 clks; done at t0+133; busy high t0+1..t0+132.
- start pulsed again at bit 10 of a frame → frame unchanged, only one done pulse.
- start held continuously, data 12'h001 then 12'h002 → back-to-back frames; dac_cs_n high ≥2 clks between them; second frame accepted the cycle after the first done.
- Reset asserted at bit 20 → dac_cs_n=1, sck=0, busy=0 immediately; no done; next frame transmits correctly.
- DAC_SPI_READBACK_EN defined; dac_out driven with 32'hDEADBEEF aligned to SCK rises → rb_data=32'hDEADBEEF at done. With the macro undefined → rb_data=0.
